bus_fill_master: RTL

Bus-initiator block that drives the CPU-side bus (address, read/write strobe, write data) into the existing address decoder, RAMs and ROMs. It performs a programmable block fill of memory, and optionally a read-back verify. It paces every bus transaction on `cpu_clken`, exactly as the 6502 core does. It is used for power-up clearing of WRAM/VRAM and as the stimulus engine for memory-map bring-up, muxed with the CPU onto `A`/`r_w`/`cpudata_out`.

---
 rtl/bus_fill_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bus_fill_master.sv
// Bus initiator that block-fills memory on cpu_clken-paced bus cycles,
// with an optional pipelined read-back verify pass.
module bus_fill_master #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_clken,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              incr,
   input  logic              verify,
   output logic [ADDR_W-1:0] A,
   output logic              r_w,
   output logic [DATA_W-1:0] dout,
   input  logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr
);

   localparam int CW = LEN_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [CW-1:0]     len_q;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] fill_q;
   logic [DATA_W-1:0] exp_q;
   logic              incr_q;
   logic              verify_q;

   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic              last;

   always_comb begin
      cur_addr = base_q + ADDR_W'(cnt);
      cur_data = incr_q ? (fill_q + DATA_W'(cnt)) : fill_q;
      last     = (cnt == len_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         A        <= '0;
         r_w      <= 1'b1;
         dout     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         err_addr <= '0;
         base_q   <= '0;
         len_q    <= '0;
         cnt      <= '0;
         fill_q   <= '0;
         exp_q    <= '0;
         incr_q   <= 1'b0;
         verify_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               // Bus is already parked here; acceptance ignores cpu_clken.
               if (start) begin
                  base_q   <= base_addr;
                  len_q    <= (length == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, length};
                  fill_q   <= fill_data;
                  incr_q   <= incr;
                  verify_q <= verify;
                  cnt      <= '0;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  err_addr <= '0;
                  busy     <= 1'b1;
                  state    <= S_WRITE;
               end
            end

            S_WRITE: begin
               if (cpu_clken) begin
                  if (!last) begin
                     A    <= cur_addr;
                     r_w  <= 1'b0;
                     dout <= cur_data;
                     cnt  <= cnt + 1'b1;
                  end else if (verify_q) begin
                     A     <= base_q;
                     r_w   <= 1'b1;
                     dout  <= '0;
                     exp_q <= fill_q;
                     cnt   <= {{(CW-1){1'b0}}, 1'b1};
                     state <= S_READ;
                  end else begin
                     A     <= '0;
                     r_w   <= 1'b1;
                     dout  <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end

            S_READ: begin
               // din belongs to the read presented on the previous enabled edge;
               // exp_q and A still describe that read while this edge samples it.
               if (cpu_clken) begin
                  if (din != exp_q) begin
                     error    <= 1'b1;
                     err_addr <= A;
                     A        <= '0;
                     r_w      <= 1'b1;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= S_DONE;
                  end else if (!last) begin
                     A     <= cur_addr;
                     exp_q <= cur_data;
                     cnt   <= cnt + 1'b1;
                  end else begin
                     A     <= '0;
                     r_w   <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
